// File: rtl/bus_timer_responder.sv
// Memory-mapped timer/LED/SYSTICK responder on the MEM-stage data bus.
// Reads are combinational from current register state; writes land on the next posedge.
module bus_timer_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          PRESCALE  = 1,
    parameter int          LED_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          addr,
    input  logic                 Mem_rd,
    input  logic                 Mem_wr,
    input  logic [31:0]          Write_data,
    output logic [31:0]          Read_data,
    output logic                 hit,
    output logic                 irq,
    output logic [LED_WIDTH-1:0] leds
);

    localparam int             PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PMAX    = PW'(PRESCALE - 1);
    localparam logic [2:0]     OFF_TH  = 3'd0;
    localparam logic [2:0]     OFF_TL  = 3'd1;
    localparam logic [2:0]     OFF_TCN = 3'd2;
    localparam logic [2:0]     OFF_LED = 3'd3;
    localparam logic [2:0]     OFF_ST  = 3'd4;

    logic [31:0]          th_q, th_d;
    logic [31:0]          tl_q, tl_d;
    logic                 en_q, en_d;
    logic                 ie_q, ie_d;
    logic                 if_q, if_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [31:0]          st_q, st_d;
    logic [PW-1:0]        pcnt_q, pcnt_d;

    logic [2:0] offset_s;
    logic       wr_s;
    logic       tick_s;
    logic       ovf_s;
    logic       unused_addr_s;

    assign hit           = (addr[31:5] == BASE_ADDR[31:5]);
    assign offset_s      = addr[4:2];
    assign unused_addr_s = ^addr[1:0];
    assign wr_s          = Mem_wr & hit;
    assign tick_s        = en_q & (pcnt_q == PMAX);
    // A TL write in the same cycle suppresses the overflow that the tick would cause.
    assign ovf_s         = tick_s & (tl_q == 32'hFFFF_FFFF) & ~(wr_s & (offset_s == OFF_TL));
    assign irq           = ie_q & if_q;
    assign leds          = led_q;

    // Read mux: pre-edge register values, zero when not a decoded read.
    always_comb begin
        Read_data = 32'h0000_0000;
        if (Mem_rd && hit) begin
            case (offset_s)
                OFF_TH:  Read_data = th_q;
                OFF_TL:  Read_data = tl_q;
                OFF_TCN: Read_data = {29'h0000_0000, if_q, ie_q, en_q};
                OFF_LED: Read_data = 32'(led_q);
                OFF_ST:  Read_data = st_q;
                default: Read_data = 32'h0000_0000;
            endcase
        end else begin
            Read_data = 32'h0000_0000;
        end
    end

    // Next-state: bus writes, prescaler, timer reload/increment, sticky flag.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        en_d   = en_q;
        ie_d   = ie_q;
        if_d   = if_q | (ie_q & ovf_s);
        led_d  = led_q;
        st_d   = st_q + 32'd1;
        pcnt_d = pcnt_q;

        if (en_q) begin
            pcnt_d = tick_s ? PW'(0) : (pcnt_q + PW'(1));
        end else begin
            pcnt_d = pcnt_q;
        end

        if (wr_s && (offset_s == OFF_TL)) begin
            tl_d = Write_data;
        end else if (tick_s) begin
            tl_d = ovf_s ? th_q : (tl_q + 32'd1);
        end else begin
            tl_d = tl_q;
        end

        if (wr_s && (offset_s == OFF_TH)) begin
            th_d = Write_data;
        end else begin
            th_d = th_q;
        end

        if (wr_s && (offset_s == OFF_TCN)) begin
            en_d = Write_data[0];
            ie_d = Write_data[1];
            if_d = Write_data[2] | (ie_q & ovf_s);
        end else begin
            en_d = en_q;
            ie_d = ie_q;
        end

        if (wr_s && (offset_s == OFF_LED)) begin
            led_d = Write_data[LED_WIDTH-1:0];
        end else begin
            led_d = led_q;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q   <= 32'h0000_0000;
            tl_q   <= 32'h0000_0000;
            en_q   <= 1'b0;
            ie_q   <= 1'b0;
            if_q   <= 1'b0;
            led_q  <= '0;
            st_q   <= 32'h0000_0000;
            pcnt_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            en_q   <= en_d;
            ie_q   <= ie_d;
            if_q   <= if_d;
            led_q  <= led_d;
            st_q   <= st_d;
            pcnt_q <= pcnt_d;
        end
    end

endmodule
